fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the byte FIFO between `N_REQ` producers. Each producer presents bursts over a valid/ready handshake. The arbiter locks onto one producer until that producer's burst ends or hits a beat limit, then moves on. It sits directly in front of the FIFO write side and drives its write enable and data from the granted producer, with back-pressure taken from the FIFO full flag.

## Interface
Parameters:
- `N_REQ`, 4: number of producers (2..8).
- `DATA_W`, 8: data width; matches FIFO `din`.
- `MAX_BURST`, 16: maximum beats per grant (1..255).

Ports:
- `clk`: input, 1 bit. Single clock; all logic is on its rising edge.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `req_valid`: input, `N_REQ` bits. Producer i has a beat available.
- `req_data`: input, `N_REQ*DATA_W` bits. Producer i data sits in slice `[i*DATA_W +: DATA_W]`.
- `req_last`: input, `N_REQ` bits. The current beat of producer i ends its burst.
- `req_ready`: output, `N_REQ` bits. Beat of producer i is accepted this cycle.
- `fifo_full`: input, 1 bit. FIFO full flag.
- `fifo_wr_en`: output, 1 bit. Write strobe to the FIFO.
- `fifo_din`: output, `DATA_W` bits. Write data to the FIFO.
- `grant_valid`: output, 1 bit. A producer currently owns the port.
- `grant_id`: output, `$clog2(N_REQ)` bits. Index of the owning producer.
- `beat_cnt`: output, 8 bits. Beats accepted in the current grant.

## Operation
- FSM states are `IDLE` and `LOCK`.
- **IDLE**
  - Scans `req_valid`, starting at `rr_ptr`, and takes the first asserted index.
  - If one is found: register `grant_id` = winner, set `beat_cnt` = 0, go to `LOCK`.
  - No beats are accepted in `IDLE`.
- **LOCK**
  - A beat is accepted when `req_valid[grant_id]` && !`fifo_full`.
  - `req_ready[grant_id]` = !`fifo_full`. All other `req_ready` bits are 0.
  - `fifo_wr_en` = accept. `fifo_din` = `req_data` slice of `grant_id`. Both are combinational.
  - Each accept increments `beat_cnt`.
- **Release:** an accept with `req_last[grant_id]` = 1, or an accept that makes `beat_cnt` reach `MAX_BURST`.
  - Next state is `IDLE`.
  - `rr_ptr` becomes (`grant_id`+1) mod `N_REQ`.
- A locked producer that drops `req_valid` mid-burst keeps the grant. There is no timeout.
- `fifo_full` only stalls. The arbiter never asserts `fifo_wr_en` while `fifo_full` = 1, so the FIFO never overflows.
- `req_last` is ignored on non-accepted cycles.
- Reset values, and reset mid-burst:
  - Async assertion forces `IDLE`, `rr_ptr` = 0, `grant_id` = 0, `beat_cnt` = 0, `grant_valid` = 0.
  - All `req_ready` = 0, `fifo_wr_en` = 0, `fifo_din` = 0.
  - The partial burst is abandoned. Beats already written stay in the FIFO.

## Timing
- Arbitration latency: `req_valid` seen in `IDLE` at edge k gives `grant_valid` = 1 and the first accept possible in cycle k+1.
- Each burst costs one `IDLE` bubble cycle. Peak throughput is `MAX_BURST`/(`MAX_BURST`+1) beats per cycle.
- `grant_valid` is 1 exactly while in `LOCK`, and drops in the cycle after the release beat.
- `beat_cnt` shows accepted beats and updates on the edge after each accept.
- `fifo_full` → `fifo_wr_en` path is combinational, with zero-cycle back-pressure.
- **Fairness:** when all producers request continuously, grants go 0,1,2,…,N_REQ-1,0,…. No producer waits more than (`N_REQ`-1) grants.

## Structure
- Package `fifo_arb_pkg` holds:
  - the `arb_state_t` enum (`IDLE`, `LOCK`);
  - the constant `GRANT_W` = `$clog2(N_REQ)` helper;
  - the default `MAX_BURST`.
- Sub-module `rr_pick` is a combinational rotate/priority-encode/rotate-back. Inputs are `req_valid` and `rr_ptr`. Outputs are `found` and `idx`.
- The top level holds the FSM, `rr_ptr`, `beat_cnt`, the data mux and the ready/write decode.

## Test plan
- **Reset:** hold `rst`=1 with `req_valid`=4'b1111, then release. Required: one `IDLE` cycle, then `grant_id`=0, `grant_valid`=1; all outputs 0 during reset.
- **Round-robin:** all 4 producers send 2-beat bursts (`req_last` on beat 2) continuously, with data = {id, beat}. Required:
  - FIFO receives 0x00,0x01,0x10,0x11,0x20,0x21,0x30,0x31,0x00…;
  - one idle cycle between bursts.
- **Burst limit:** `MAX_BURST`=16 and producer 1 streams 40 beats without `req_last`, with producer 2 also valid. Required:
  - release after beat 16;
  - producer 2 is granted next;
  - producer 1 resumes later at beat 17.
- **Back-pressure:** `fifo_full`=1 for 5 cycles in the middle of a burst from producer 3. Required:
  - `fifo_wr_en`=0 and `req_ready`=0 for those 5 cycles;
  - no beat lost or duplicated;
  - `beat_cnt` frozen.
- **Gap:** the locked producer drops `req_valid` for 3 cycles while others request. Required: grant held, `beat_cnt` unchanged, the burst completes after the gap.
- **Reset mid-burst:** assert `rst` after beat 3 of 8. Required: immediate `IDLE`, `beat_cnt`=0, `rr_ptr`=0; the next grant goes to the lowest requesting index.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// The state encodings are kept as plain constants for older users of this slice.
package fifo_arb_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_LOCK = 1'b1;

   typedef enum logic [0:0] {
      IDLE = ST_IDLE,
      LOCK = ST_LOCK
   } arb_state_t;

   localparam int DEF_MAX_BURST = 16;

   // Width of a producer index; a single producer still needs one bit.
   function automatic int grant_w(input int n_req);
      return (n_req > 1) ? $clog2(n_req) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: rotate the request vector so rr_ptr sits at bit 0,
// take the lowest set bit, then rotate that offset back to a producer index.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [grant_w(N_REQ)-1:0] rr_ptr,
   output logic                      found,
   output logic [grant_w(N_REQ)-1:0] idx
);

   localparam int GRANT_W = grant_w(N_REQ);

   logic [2*N_REQ-1:0] dbl_s;
   logic [N_REQ-1:0]   rot_s;
   int                 off_s;
   int                 sum_s;

   // Rotate, priority-encode from the pointer upwards, rotate back
   always_comb begin
      dbl_s = {req_valid, req_valid};
      rot_s = dbl_s[rr_ptr +: N_REQ];
      found = 1'b0;
      off_s = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot_s[k]) begin
            found = 1'b1;
            off_s = k;
         end else begin
            off_s = off_s;
         end
      end
      sum_s = (int'(rr_ptr) + off_s) % N_REQ;
      idx   = GRANT_W'(sum_s);
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the byte FIFO write port between N_REQ producers.
// A grant is held until the burst's last beat or the beat limit is accepted.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   input  logic [N_REQ-1:0]          req_last,
   output logic [N_REQ-1:0]          req_ready,
   input  logic                      fifo_full,
   output logic                      fifo_wr_en,
   output logic [DATA_W-1:0]         fifo_din,
   output logic                      grant_valid,
   output logic [grant_w(N_REQ)-1:0] grant_id,
   output logic [7:0]                beat_cnt
);

   localparam int                 GRANT_W     = grant_w(N_REQ);
   localparam logic [7:0]         BURST_LIMIT = 8'(MAX_BURST);
   localparam logic [GRANT_W-1:0] LAST_ID     = GRANT_W'(N_REQ - 1);

   arb_state_t         state_r;
   logic [GRANT_W-1:0] rr_ptr_r;
   logic [GRANT_W-1:0] grant_id_r;
   logic [7:0]         beat_cnt_r;
   logic               pick_found_s;
   logic [GRANT_W-1:0] pick_idx_s;
   logic               accept_s;
   logic               release_s;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_r),
      .found     (pick_found_s),
      .idx       (pick_idx_s)
   );

   // Ready/write decode and data mux; fifo_full gates the strobe with no delay
   always_comb begin
      req_ready = {N_REQ{1'b0}};
      fifo_din  = {DATA_W{1'b0}};
      accept_s  = 1'b0;
      release_s = 1'b0;
      if (state_r == LOCK) begin
         req_ready[grant_id_r] = !fifo_full;
         fifo_din  = req_data[grant_id_r*DATA_W +: DATA_W];
         accept_s  = req_valid[grant_id_r] && !fifo_full;
         release_s = accept_s &&
                     (req_last[grant_id_r] || (beat_cnt_r + 8'd1 == BURST_LIMIT));
      end else begin
         accept_s  = 1'b0;
         release_s = 1'b0;
      end
   end

   assign fifo_wr_en  = accept_s;
   assign grant_valid = (state_r == LOCK);
   assign grant_id    = grant_id_r;
   assign beat_cnt    = beat_cnt_r;

   // Grant FSM, round-robin pointer and per-grant beat counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         rr_ptr_r   <= {GRANT_W{1'b0}};
         grant_id_r <= {GRANT_W{1'b0}};
         beat_cnt_r <= 8'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (pick_found_s) begin
                  grant_id_r <= pick_idx_s;
                  beat_cnt_r <= 8'd0;
                  state_r    <= LOCK;
               end
            end
            LOCK: begin
               if (accept_s) begin
                  beat_cnt_r <= beat_cnt_r + 8'd1;
               end
               if (release_s) begin
                  state_r  <= IDLE;
                  rr_ptr_r <= (grant_id_r == LAST_ID) ? {GRANT_W{1'b0}}
                                                      : grant_id_r + {{(GRANT_W-1){1'b0}}, 1'b1};
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (4 producers, 8-bit data, 16-beat limit).
module tb_fifo_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic        fifo_full;
   logic        fifo_wr_en;
   logic [7:0]  fifo_din;
   logic        grant_valid;
   logic [1:0]  grant_id;
   logic [7:0]  beat_cnt;

   int checks = 0;
   int errors = 0;
   int en[4], sent[4], avail[4], blen[4];
   logic gap, full;
   logic [7:0] got[$];
   logic [7:0] exp_d;

   fifo_wr_arbiter dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
      .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .grant_valid(grant_valid),
      .grant_id(grant_id), .beat_cnt(beat_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Producer model: blen=0 streams a byte counter with no last, else {id, beat-in-burst}
   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         logic [7:0] d;
         int b;
         req_valid[i] = (en[i] != 0) && (sent[i] < avail[i]) && !(i == 0 && gap);
         if (blen[i] == 0) begin
            d = sent[i][7:0];
            req_last[i] = 1'b0;
         end else begin
            b = sent[i] % blen[i];
            d = {i[3:0], b[3:0]};
            req_last[i] = (((sent[i] + 1) % blen[i]) == 0);
         end
         req_data[i*8 +: 8] = d;
      end
      fifo_full = full;
      #1;
   endtask

   task automatic adv();
      chk("wr_while_full", {31'd0, fifo_wr_en & fifo_full}, 32'd0);
      if (fifo_wr_en === 1'b1) got.push_back(fifo_din);
      for (int i = 0; i < 4; i++)
         if (req_valid[i] && req_ready[i]) sent[i]++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         en[i] = 0; sent[i] = 0; avail[i] = 0; blen[i] = 0;
      end
      gap = 1'b0;
      full = 1'b0;
      got.delete();
      drive();
      adv();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      gap = 1'b0;
      full = 1'b0;
      for (int i = 0; i < 4; i++) begin
         en[i] = 1; sent[i] = 0; avail[i] = 100; blen[i] = 2;
      end
      @(negedge clk);

      // Reset held with every producer requesting
      for (int c = 0; c < 2; c++) begin
         drive();
         chk("rst_gv", grant_valid, 32'd0);
         chk("rst_ready", req_ready, 32'd0);
         chk("rst_wr", fifo_wr_en, 32'd0);
         chk("rst_din", fifo_din, 32'd0);
         chk("rst_cnt", beat_cnt, 32'd0);
         chk("rst_gid", grant_id, 32'd0);
         adv();
      end
      rst = 1'b0;
      drive();
      chk("idle_gv", grant_valid, 32'd0);
      chk("idle_ready", req_ready, 32'd0);
      adv();

      // Round-robin of 2-beat bursts: write, write, bubble
      for (int c = 0; c < 24; c++) begin
         drive();
         if (c % 3 == 2) begin
            chk("rr_bubble_gv", grant_valid, 32'd0);
            chk("rr_bubble_wr", fifo_wr_en, 32'd0);
         end else begin
            exp_d = {4'((c / 3) % 4), 4'(c % 3)};
            chk("rr_gv", grant_valid, 32'd1);
            chk("rr_gid", grant_id, (c / 3) % 4);
            chk("rr_wr", fifo_wr_en, 32'd1);
            chk("rr_din", fifo_din, exp_d);
            chk("rr_cnt", beat_cnt, c % 3);
         end
         adv();
      end

      // Burst limit: producer 1 streams without last, producer 2 waits
      do_reset();
      en[1] = 1; avail[1] = 40; blen[1] = 0;
      en[2] = 1; avail[2] = 4;  blen[2] = 4;
      for (int c = 0; c < 24; c++) begin
         drive();
         case (c)
            0:  chk("bl_idle_gv", grant_valid, 32'd0);
            1: begin
               chk("bl_first_gid", grant_id, 32'd1);
               chk("bl_first_din", fifo_din, 32'h00);
            end
            16: begin
               chk("bl_b16_din", fifo_din, 32'h0F);
               chk("bl_b16_cnt", beat_cnt, 32'd15);
               chk("bl_b16_wr", fifo_wr_en, 32'd1);
            end
            17: begin
               chk("bl_rel_gv", grant_valid, 32'd0);
               chk("bl_rel_cnt", beat_cnt, 32'd16);
               chk("bl_rel_ready", req_ready, 32'd0);
            end
            18: begin
               chk("bl_p2_gid", grant_id, 32'd2);
               chk("bl_p2_din", fifo_din, 32'h20);
            end
            21: chk("bl_p2_last", fifo_din, 32'h23);
            22: chk("bl_idle2_gv", grant_valid, 32'd0);
            23: begin
               chk("bl_resume_gid", grant_id, 32'd1);
               chk("bl_resume_din", fifo_din, 32'h10);
               chk("bl_resume_cnt", beat_cnt, 32'd0);
            end
            default: ;
         endcase
         adv();
      end

      // Back-pressure: fifo_full for 5 cycles mid-burst from producer 3
      do_reset();
      en[3] = 1; avail[3] = 8; blen[3] = 8;
      for (int c = 0; c < 15; c++) begin
         full = (c >= 4 && c <= 8);
         drive();
         if (c >= 4 && c <= 8) begin
            chk("bp_wr", fifo_wr_en, 32'd0);
            chk("bp_ready", req_ready, 32'd0);
            chk("bp_cnt", beat_cnt, 32'd3);
            chk("bp_gv", grant_valid, 32'd1);
         end
         if (c == 9) begin
            chk("bp_resume_din", fifo_din, 32'h33);
            chk("bp_resume_wr", fifo_wr_en, 32'd1);
         end
         if (c == 13) chk("bp_last_cnt", beat_cnt, 32'd7);
         if (c == 14) begin
            chk("bp_done_gv", grant_valid, 32'd0);
            chk("bp_done_cnt", beat_cnt, 32'd8);
         end
         adv();
      end
      full = 1'b0;
      chk("bp_count", got.size(), 32'd8);
      for (int k = 0; k < 8; k++) begin
         exp_d = 8'h30 + 8'(k);
         if (k < got.size()) chk("bp_data", got[k], exp_d);
      end

      // Gap: producer 0 drops valid for 3 cycles while producer 2 requests
      do_reset();
      en[0] = 1; avail[0] = 6; blen[0] = 6;
      en[2] = 1; avail[2] = 2; blen[2] = 2;
      for (int c = 0; c < 12; c++) begin
         gap = (c >= 3 && c <= 5);
         drive();
         if (c >= 3 && c <= 5) begin
            chk("gap_gid", grant_id, 32'd0);
            chk("gap_gv", grant_valid, 32'd1);
            chk("gap_wr", fifo_wr_en, 32'd0);
            chk("gap_cnt", beat_cnt, 32'd2);
            chk("gap_ready", req_ready, 32'd1);
         end
         if (c == 6) chk("gap_resume_din", fifo_din, 32'h02);
         if (c == 9) begin
            chk("gap_last_din", fifo_din, 32'h05);
            chk("gap_last_cnt", beat_cnt, 32'd5);
         end
         if (c == 10) chk("gap_rel_gv", grant_valid, 32'd0);
         if (c == 11) begin
            chk("gap_next_gid", grant_id, 32'd2);
            chk("gap_next_din", fifo_din, 32'h20);
         end
         adv();
      end
      gap = 1'b0;

      // Reset mid-burst: producer 3 interrupted after beat 3 of 8
      do_reset();
      en[1] = 1; avail[1] = 1; blen[1] = 1;
      en[3] = 1; avail[3] = 8; blen[3] = 8;
      for (int c = 0; c < 6; c++) begin
         drive();
         if (c == 1) begin
            chk("mr_p1_gid", grant_id, 32'd1);
            chk("mr_p1_din", fifo_din, 32'h10);
         end
         if (c == 3) begin
            chk("mr_p3_gid", grant_id, 32'd3);
            chk("mr_p3_din", fifo_din, 32'h30);
         end
         adv();
      end
      drive();
      chk("mr_pre_cnt", beat_cnt, 32'd3);
      rst = 1'b1;
      #1;
      chk("mr_gv", grant_valid, 32'd0);
      chk("mr_cnt", beat_cnt, 32'd0);
      chk("mr_gid", grant_id, 32'd0);
      chk("mr_wr", fifo_wr_en, 32'd0);
      chk("mr_ready", req_ready, 32'd0);
      chk("mr_din", fifo_din, 32'd0);
      adv();
      rst = 1'b0;
      en[0] = 1; avail[0] = 1; blen[0] = 1;
      drive();
      chk("mr_idle_gv", grant_valid, 32'd0);
      adv();
      drive();
      chk("mr_next_gv", grant_valid, 32'd1);
      chk("mr_next_gid", grant_id, 32'd0);
      chk("mr_next_din", fifo_din, 32'h00);
      adv();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
